k005293_tile_shifter: RTL

- Receive end of the tilemap address generator.
- Captures CHARRAM line data and per-tile attributes (priority, palette, hflip) for tilemap layers A and B.
- Serialises 8 four-bit pixels per tile per layer, aligned by the fine-scroll load strobes.
- Outputs per-layer colour codes, priority and opacity to the priority mixer, one pixel per 6 MHz pixel enable.

---
 rtl/k005293_tile_shifter_pkg.sv | 11 +
 rtl/k005293_layer_shifter.sv | 78 +++++++
 rtl/k005293_tile_shifter.sv | 58 +++++
 3 files changed

// File: rtl/k005293_tile_shifter_pkg.sv
// Shared widths and phase constants for the K005293 tilemap pixel shifter.
package k005293_tile_shifter_pkg;
   localparam int PIXW  = 4;
   localparam int PALW  = 7;
   localparam int PRIW  = 4;
   localparam int CODEW = PALW + PIXW;
   localparam int LINEW = 8 * PIXW;

   localparam logic [2:0] STAGE_A_PHASE = 3'd7;
   localparam logic [2:0] STAGE_B_PHASE = 3'd3;
endpackage

// File: rtl/k005293_layer_shifter.sv
// One tilemap layer: pending line/attributes, active attributes, 8-pixel shifter
// with flip-direction select, and registered colour/priority outputs.
module k005293_layer_shifter
   import k005293_tile_shifter_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_cen_n,
   input  logic             i_stage,
   input  logic             i_load_n,
   input  logic [LINEW-1:0] i_chardata,
   input  logic [PRIW-1:0]  i_priority,
   input  logic [PALW-1:0]  i_palette,
   input  logic             i_hflip,
   output logic [CODEW-1:0] o_code,
   output logic [PRIW-1:0]  o_prio,
   output logic             o_opaque
);
   logic [LINEW-1:0] r_pend_line;
   logic [PRIW-1:0]  r_pend_prio;
   logic [PALW-1:0]  r_pend_pal;
   logic             r_pend_hflip;

   logic [LINEW-1:0] r_shift;
   logic [PRIW-1:0]  r_act_prio;
   logic [PALW-1:0]  r_act_pal;
   logic             r_act_hflip;

   logic [PIXW-1:0]  r_out_pix;
   logic [PRIW-1:0]  r_out_prio;
   logic [PALW-1:0]  r_out_pal;

   logic [PIXW-1:0]  w_pix;
   logic [LINEW-1:0] w_shifted;

   // Direction follows the flip bit captured at load, never the live input.
   assign w_pix     = r_act_hflip ? r_shift[PIXW-1:0] : r_shift[LINEW-1 -: PIXW];
   assign w_shifted = r_act_hflip ? (r_shift >> PIXW) : (r_shift << PIXW);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_pend_line  <= '0;
         r_pend_prio  <= '0;
         r_pend_pal   <= '0;
         r_pend_hflip <= 1'b0;
         r_shift      <= '0;
         r_act_prio   <= '0;
         r_act_pal    <= '0;
         r_act_hflip  <= 1'b0;
         r_out_pix    <= '0;
         r_out_prio   <= '0;
         r_out_pal    <= '0;
      end else if (!i_cen_n) begin
         if (i_stage) begin
            r_pend_line  <= i_chardata;
            r_pend_prio  <= i_priority;
            r_pend_pal   <= i_palette;
            r_pend_hflip <= i_hflip;
         end
         // A load in the same enable as staging takes the previous pending set.
         if (!i_load_n) begin
            r_shift     <= r_pend_line;
            r_act_prio  <= r_pend_prio;
            r_act_pal   <= r_pend_pal;
            r_act_hflip <= r_pend_hflip;
         end else begin
            r_shift     <= w_shifted;
         end
         r_out_pix  <= w_pix;
         r_out_prio <= r_act_prio;
         r_out_pal  <= r_act_pal;
      end
   end

   assign o_code   = {r_out_pal, r_out_pix};
   assign o_prio   = r_out_prio;
   assign o_opaque = |r_out_pix;
endmodule

// File: rtl/k005293_tile_shifter.sv
// Tilemap receive end: decodes pixel phase into per-layer staging enables and
// drives the A and B layer shifters feeding the priority mixer.
module k005293_tile_shifter
   import k005293_tile_shifter_pkg::*;
(
   input  logic             i_EMU_MCLK,
   input  logic             i_EMU_RST_n,
   input  logic             i_EMU_6MPOSCEN_n,
   input  logic [2:0]       i_HPHASE,
   input  logic [LINEW-1:0] i_CHARDATA,
   input  logic [PRIW-1:0]  i_PRIORITY,
   input  logic [PALW-1:0]  i_PALETTE,
   input  logic             i_HFLIPBIT,
   input  logic             i_SHIFTA_n,
   input  logic             i_SHIFTB_n,
   output logic [CODEW-1:0] o_TMA_CODE,
   output logic [CODEW-1:0] o_TMB_CODE,
   output logic [PRIW-1:0]  o_TMA_PRIO,
   output logic [PRIW-1:0]  o_TMB_PRIO,
   output logic             o_TMA_OPAQUE,
   output logic             o_TMB_OPAQUE
);
   logic w_stage_a;
   logic w_stage_b;

   assign w_stage_a = (i_HPHASE == STAGE_A_PHASE);
   assign w_stage_b = (i_HPHASE == STAGE_B_PHASE);

   k005293_layer_shifter u_layer_a (
      .i_clk      (i_EMU_MCLK),
      .i_rst_n    (i_EMU_RST_n),
      .i_cen_n    (i_EMU_6MPOSCEN_n),
      .i_stage    (w_stage_a),
      .i_load_n   (i_SHIFTA_n),
      .i_chardata (i_CHARDATA),
      .i_priority (i_PRIORITY),
      .i_palette  (i_PALETTE),
      .i_hflip    (i_HFLIPBIT),
      .o_code     (o_TMA_CODE),
      .o_prio     (o_TMA_PRIO),
      .o_opaque   (o_TMA_OPAQUE)
   );

   k005293_layer_shifter u_layer_b (
      .i_clk      (i_EMU_MCLK),
      .i_rst_n    (i_EMU_RST_n),
      .i_cen_n    (i_EMU_6MPOSCEN_n),
      .i_stage    (w_stage_b),
      .i_load_n   (i_SHIFTB_n),
      .i_chardata (i_CHARDATA),
      .i_priority (i_PRIORITY),
      .i_palette  (i_PALETTE),
      .i_hflip    (i_HFLIPBIT),
      .o_code     (o_TMB_CODE),
      .o_prio     (o_TMB_PRIO),
      .o_opaque   (o_TMB_OPAQUE)
   );
endmodule
